ysyx_24100005_mcore: RTL and testbench

Multi-cycle RV32I/RV32E integer core: successor to the single-cycle addi-only top. It fetches over a valid-handshaked instruction port instead of a combinational `inst` input. It executes a small integer subset with correct sign extension and a hardwired x0. It reports retirement, halt and illegal-instruction status to the simulation harness.

---
 rtl/ysyx_24100005_mcore_if.sv | 11 +
 rtl/ysyx_24100005_mcore.sv | 172 +++++++++++++++++
 tb/tb_ysyx_24100005_mcore.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24100005_mcore_if.sv
// Instruction-fetch port of the multi-cycle core: request/address out,
// valid/instruction back.
interface ysyx_24100005_mcore_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid;
   logic [31:0] imem_inst;

   modport master (output imem_req, output imem_addr, input imem_valid, input imem_inst);
   modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_inst);
endinterface

// File: rtl/ysyx_24100005_mcore.sv
// Multi-cycle RV32I/RV32E subset core: FETCH over a valid handshake, EXEC one
// instruction, HALT on EBREAK or any unsupported/invalid instruction.
module ysyx_24100005_mcore #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          NR_REG   = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   ysyx_24100005_mcore_if.master     imem,
   output logic [31:0]               pc,
   output logic                      retire,
   output logic                      halt,
   output logic                      illegal,
   output logic [31:0]               halt_code
);
   localparam int IDX_W = (NR_REG == 16) ? 4 : 5;

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic        retire_q, retire_d;
   logic        halt_q, halt_d;
   logic        illegal_q, illegal_d;
   logic [31:0] halt_code_q, halt_code_d;
   logic [31:0] rf_q [NR_REG];
   logic        rf_we;

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [4:0]  rd_a, rs1_a, rs2_a;
   logic [31:0] imm_i, imm_u, imm_j;
   logic [31:0] rs1_v, rs2_v;
   logic [31:0] wd, npc;
   logic        op_ok, use1, use2, user, is_jump, is_ebreak, e_bad, legal;

   assign opcode = ir_q[6:0];
   assign rd_a   = ir_q[11:7];
   assign f3     = ir_q[14:12];
   assign rs1_a  = ir_q[19:15];
   assign rs2_a  = ir_q[24:20];
   assign f7     = ir_q[31:25];
   assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
   assign imm_u  = {ir_q[31:12], 12'b0};
   assign imm_j  = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

   assign rs1_v  = (rs1_a == 5'd0) ? 32'd0 : rf_q[rs1_a[IDX_W-1:0]];
   assign rs2_v  = (rs2_a == 5'd0) ? 32'd0 : rf_q[rs2_a[IDX_W-1:0]];

   always_comb begin
      op_ok     = 1'b0;
      use1      = 1'b0;
      use2      = 1'b0;
      user      = 1'b0;
      is_jump   = 1'b0;
      is_ebreak = 1'b0;
      wd        = 32'd0;
      npc       = pc_q + 32'd4;
      case (opcode)
         7'b0010011: begin
            op_ok = (f3 == 3'b000);
            use1  = 1'b1;
            user  = 1'b1;
            wd    = rs1_v + imm_i;
         end
         7'b0110011: begin
            op_ok = (f3 == 3'b000) && ((f7 == 7'b0000000) || (f7 == 7'b0100000));
            use1  = 1'b1;
            use2  = 1'b1;
            user  = 1'b1;
            wd    = f7[5] ? (rs1_v - rs2_v) : (rs1_v + rs2_v);
         end
         7'b0110111: begin
            op_ok = 1'b1;
            user  = 1'b1;
            wd    = imm_u;
         end
         7'b0010111: begin
            op_ok = 1'b1;
            user  = 1'b1;
            wd    = pc_q + imm_u;
         end
         7'b1101111: begin
            op_ok   = 1'b1;
            user    = 1'b1;
            is_jump = 1'b1;
            wd      = pc_q + 32'd4;
            npc     = pc_q + imm_j;
         end
         7'b1100111: begin
            op_ok   = (f3 == 3'b000);
            use1    = 1'b1;
            user    = 1'b1;
            is_jump = 1'b1;
            wd      = pc_q + 32'd4;
            npc     = (rs1_v + imm_i) & ~32'd1;
         end
         7'b1110011: is_ebreak = (ir_q == 32'h0010_0073);
         default: ;
      endcase
      // RV32E only has x0..x15; any referenced field with bit 4 set is out of range
      e_bad = (NR_REG == 16) && ((use1 && rs1_a[4]) || (use2 && rs2_a[4]) || (user && rd_a[4]));
      legal = op_ok && !e_bad && !(is_jump && npc[1]);
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      retire_d    = 1'b0;
      halt_d      = halt_q;
      illegal_d   = illegal_q;
      halt_code_d = halt_code_q;
      rf_we       = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (imem.imem_valid) begin
               ir_d    = imem.imem_inst;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_ebreak || !legal) begin
               state_d     = S_HALT;
               halt_d      = 1'b1;
               illegal_d   = !is_ebreak;
               halt_code_d = rf_q[10];
            end else begin
               rf_we    = (rd_a != 5'd0);
               pc_d     = npc;
               retire_d = 1'b1;
               state_d  = S_FETCH;
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_FETCH;
         pc_q        <= RESET_PC;
         ir_q        <= 32'd0;
         retire_q    <= 1'b0;
         halt_q      <= 1'b0;
         illegal_q   <= 1'b0;
         halt_code_q <= 32'd0;
         for (int i = 0; i < NR_REG; i++) rf_q[i] <= 32'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         retire_q    <= retire_d;
         halt_q      <= halt_d;
         illegal_q   <= illegal_d;
         halt_code_q <= halt_code_d;
         if (rf_we) rf_q[rd_a[IDX_W-1:0]] <= wd;
      end
   end

   // Request is gated by reset so it stays low while rst is asserted
   assign imem.imem_req  = (state_q == S_FETCH) && rst;
   assign imem.imem_addr = pc_q;
   assign pc             = pc_q;
   assign retire         = retire_q;
   assign halt           = halt_q;
   assign illegal        = illegal_q;
   assign halt_code      = halt_code_q;
endmodule

// File: tb/tb_ysyx_24100005_mcore.sv
// Bench for ysyx_24100005_mcore: directed programs plus random ALU programs
// compared against an ISA-level register model.
module tb_ysyx_24100005_mcore;
   localparam logic [31:0] RPC    = 32'h8000_0000;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc, halt_code, pc_e, halt_code_e;
   logic        retire, halt, illegal, retire_e, halt_e, illegal_e;

   ysyx_24100005_mcore_if bus ();
   ysyx_24100005_mcore_if bus_e ();

   ysyx_24100005_mcore #(.RESET_PC(RPC), .NR_REG(32)) u_dut (
      .clk(clk), .rst(rst), .imem(bus.master), .pc(pc), .retire(retire),
      .halt(halt), .illegal(illegal), .halt_code(halt_code));

   ysyx_24100005_mcore #(.RESET_PC(RPC), .NR_REG(16)) u_dut_e (
      .clk(clk), .rst(rst), .imem(bus_e.master), .pc(pc_e), .retire(retire_e),
      .halt(halt_e), .illegal(illegal_e), .halt_code(halt_code_e));

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] mem [64];
   int          stall_cnt = 0;
   bit          rand_stall = 0;
   int          ret_cnt = 0;
   int          ret_cnt_e = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm, input logic [6:0] op);
      return {imm, rs1, 3'b000, rd, op};
   endfunction
   function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input bit sub);
      return {sub ? 7'b0100000 : 7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_u(input logic [4:0] rd, input logic [19:0] imm,
                                         input logic [6:0] op);
      return {imm, rd, op};
   endfunction
   function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] off);
      return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
   endfunction

   // Instruction memory responder: answers every cycle unless stalled
   initial begin
      logic [31:0] off;
      bus.imem_valid   = 1'b0;
      bus.imem_inst    = 32'd0;
      bus_e.imem_valid = 1'b1;
      bus_e.imem_inst  = enc_i(5'd16, 5'd0, 12'd1, 7'b0010011);
      forever begin
         @(negedge clk);
         off = bus.imem_addr - RPC;
         if (stall_cnt > 0) begin
            bus.imem_valid = 1'b0;
            bus.imem_inst  = $urandom;
            stall_cnt--;
         end else if (rand_stall && $urandom_range(0, 2) == 0) begin
            bus.imem_valid = 1'b0;
            bus.imem_inst  = $urandom;
         end else begin
            bus.imem_valid = 1'b1;
            bus.imem_inst  = mem[off[7:2]];
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (retire)   ret_cnt++;
         if (retire_e) ret_cnt_e++;
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 64; i++) mem[i] = 32'hFFFF_FFFF;
   endtask

   task automatic do_reset(input bit check);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      if (check) begin
         chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
         chk("rst_pc", pc, RPC);
         chk("rst_halt", {31'd0, halt}, 32'd0);
         chk("rst_illegal", {31'd0, illegal}, 32'd0);
         chk("rst_retire", {31'd0, retire}, 32'd0);
         chk("rst_code", halt_code, 32'd0);
      end
      rst = 1'b1;
   endtask

   task automatic wait_halt(input int budget);
      int n = 0;
      while (!halt && n < budget) begin
         @(negedge clk);
         n++;
      end
      #1;
      chk("halt_reached", {31'd0, halt}, 32'd1);
   endtask

   initial begin
      int          base, n, k, kind;
      logic [31:0] mdl [32];
      logic [31:0] pcm, v;
      logic [4:0]  rd, rs1, rs2;
      logic [11:0] imm12;
      logic [19:0] imm20;

      // ADDI chain and cycle timing
      clear_mem();
      mem[0] = enc_i(5'd1, 5'd0, 12'd5, 7'b0010011);
      mem[1] = enc_i(5'd1, 5'd1, 12'hFFF, 7'b0010011);
      mem[2] = enc_r(5'd10, 5'd1, 5'd0, 1'b0);
      mem[3] = EBREAK;
      do_reset(1'b0);
      base = ret_cnt;
      repeat (4) @(posedge clk);
      @(negedge clk); #1;
      chk("addi_pc4cyc", pc, RPC + 32'd8);
      chk("addi_retires", 32'(ret_cnt - base), 32'd2);
      wait_halt(50);
      chk("addi_x1", halt_code, 32'd4);
      chk("addi_haltpc", pc, RPC + 32'd12);

      // x0 hardwired and I-immediate sign extension
      clear_mem();
      mem[0] = enc_i(5'd0, 5'd0, 12'd7, 7'b0010011);
      mem[1] = enc_i(5'd2, 5'd0, 12'h800, 7'b0010011);
      mem[2] = enc_r(5'd10, 5'd2, 5'd0, 1'b0);
      mem[3] = EBREAK;
      do_reset(1'b1);
      wait_halt(50);
      chk("x0_sext", halt_code, 32'hFFFF_F800);

      // Modulo-2^32 wrap
      clear_mem();
      mem[0] = enc_i(5'd5, 5'd0, 12'hFFF, 7'b0010011);
      mem[1] = enc_i(5'd6, 5'd0, 12'd1, 7'b0010011);
      mem[2] = enc_r(5'd10, 5'd5, 5'd6, 1'b0);
      mem[3] = EBREAK;
      do_reset(1'b0);
      wait_halt(50);
      chk("add_wrap", halt_code, 32'd0);
      chk("add_wrap_ill", {31'd0, illegal}, 32'd0);

      // JAL link and target
      clear_mem();
      mem[0] = enc_jal(5'd1, 21'd16);
      mem[4] = enc_r(5'd10, 5'd1, 5'd0, 1'b0);
      mem[5] = EBREAK;
      do_reset(1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("jal_target", bus.imem_addr, RPC + 32'h10);
      wait_halt(50);
      chk("jal_link", halt_code, RPC + 32'd4);

      // JALR clears bit 0
      clear_mem();
      mem[0] = enc_jal(5'd1, 21'd8);
      mem[2] = enc_i(5'd0, 5'd1, 12'd1, 7'b1100111);
      mem[1] = enc_jal(5'd0, 21'd12);
      mem[4] = enc_i(5'd10, 5'd0, 12'd77, 7'b0010011);
      mem[5] = EBREAK;
      do_reset(1'b0);
      base = ret_cnt;
      repeat (4) @(posedge clk);
      @(negedge clk); #1;
      chk("jalr_target", bus.imem_addr, RPC + 32'd4);
      wait_halt(50);
      chk("jalr_code", halt_code, 32'd77);
      chk("jalr_retires", 32'(ret_cnt - base), 32'd4);

      // Misaligned JALR target
      clear_mem();
      mem[0] = enc_u(5'd1, 20'd0, 7'b0010111);
      mem[1] = enc_i(5'd0, 5'd1, 12'd2, 7'b1100111);
      do_reset(1'b0);
      base = ret_cnt;
      wait_halt(50);
      chk("misal_illegal", {31'd0, illegal}, 32'd1);
      chk("misal_pc", pc, RPC + 32'd4);
      chk("misal_retires", 32'(ret_cnt - base), 32'd1);

      // EBREAK halt
      clear_mem();
      mem[0] = enc_i(5'd10, 5'd0, 12'd42, 7'b0010011);
      mem[1] = EBREAK;
      do_reset(1'b1);
      base = ret_cnt;
      wait_halt(50);
      repeat (3) @(negedge clk);
      #1;
      chk("ebk_code", halt_code, 32'd42);
      chk("ebk_illegal", {31'd0, illegal}, 32'd0);
      chk("ebk_req", {31'd0, bus.imem_req}, 32'd0);
      chk("ebk_pc", pc, RPC + 32'd4);
      chk("ebk_retires", 32'(ret_cnt - base), 32'd1);

      // All-ones word is illegal
      clear_mem();
      mem[0] = enc_i(5'd10, 5'd0, 12'd3, 7'b0010011);
      do_reset(1'b1);
      wait_halt(50);
      chk("ill_flag", {31'd0, illegal}, 32'd1);
      chk("ill_pc", pc, RPC + 32'd4);
      chk("ill_code", halt_code, 32'd3);

      // Fetch stall: request and address held, no retire
      clear_mem();
      mem[0] = enc_i(5'd1, 5'd0, 12'd1, 7'b0010011);
      mem[1] = enc_i(5'd10, 5'd0, 12'd5, 7'b0010011);
      mem[2] = EBREAK;
      do_reset(1'b0);
      repeat (2) @(posedge clk);
      stall_cnt = 5;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         chk("stall_req", {31'd0, bus.imem_req}, 32'd1);
         chk("stall_addr", bus.imem_addr, RPC + 32'd4);
         if (i > 0) chk("stall_retire", {31'd0, retire}, 32'd0);
      end
      wait_halt(50);
      chk("stall_code", halt_code, 32'd5);

      // Reset during EXEC abandons the write
      clear_mem();
      mem[0] = enc_i(5'd3, 5'd0, 12'd9, 7'b0010011);
      mem[1] = enc_r(5'd10, 5'd3, 5'd0, 1'b0);
      mem[2] = EBREAK;
      do_reset(1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk); #1;
      chk("rstx_pc", pc, RPC);
      mem[0] = enc_r(5'd10, 5'd3, 5'd0, 1'b0);
      mem[1] = EBREAK;
      do_reset(1'b0);
      base = ret_cnt_e;
      wait_halt(50);
      chk("rstx_x3", halt_code, 32'd0);

      // RV32E instance: addi x16 must trap without retiring
      chk("e_halt", {31'd0, halt_e}, 32'd1);
      chk("e_illegal", {31'd0, illegal_e}, 32'd1);
      chk("e_pc", pc_e, RPC);
      chk("e_retires", 32'(ret_cnt_e - base), 32'd0);

      // Random ALU programs against an ISA-level register model
      rand_stall = 1;
      for (int t = 0; t < 25; t++) begin
         clear_mem();
         for (int r = 0; r < 32; r++) mdl[r] = 32'd0;
         pcm = RPC;
         n = $urandom_range(3, 10);
         for (int i = 0; i < n; i++) begin
            kind  = $urandom_range(0, 4);
            rd    = 5'($urandom_range(0, 31));
            rs1   = 5'($urandom_range(0, 31));
            rs2   = 5'($urandom_range(0, 31));
            imm12 = 12'($urandom);
            imm20 = 20'($urandom);
            case (kind)
               0: begin mem[i] = enc_i(rd, rs1, imm12, 7'b0010011);
                        v = mdl[rs1] + {{20{imm12[11]}}, imm12}; end
               1: begin mem[i] = enc_r(rd, rs1, rs2, 1'b0); v = mdl[rs1] + mdl[rs2]; end
               2: begin mem[i] = enc_r(rd, rs1, rs2, 1'b1); v = mdl[rs1] - mdl[rs2]; end
               3: begin mem[i] = enc_u(rd, imm20, 7'b0110111); v = {imm20, 12'd0}; end
               default: begin mem[i] = enc_u(rd, imm20, 7'b0010111); v = pcm + {imm20, 12'd0}; end
            endcase
            if (rd != 5'd0) mdl[rd] = v;
            pcm = pcm + 32'd4;
         end
         k = $urandom_range(0, 31);
         mem[n]     = enc_r(5'd10, 5'(k), 5'd0, 1'b0);
         mem[n + 1] = EBREAK;
         do_reset(1'b0);
         base = ret_cnt;
         wait_halt(300);
         chk("rnd_code", halt_code, mdl[k]);
         chk("rnd_pc", pc, RPC + 32'(4 * (n + 1)));
         chk("rnd_retires", 32'(ret_cnt - base), 32'(n + 1));
         chk("rnd_illegal", {31'd0, illegal}, 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
